// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_ext_stage
//  Purpose  : Registered MIPS immediate-extension stage with a 2-entry skid
//             FIFO between decode and execute. Optional macro IMM_LUI_EN
//             enables the LUI (UPPER, mode 5) decode.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_ext_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_mode,
    output logic [TAG_W-1:0]  out_tag
);

    localparam logic [2:0] c_MODE_NONE     = 3'd0;
    localparam logic [2:0] c_MODE_ZERO     = 3'd0;
    localparam logic [2:0] c_MODE_SIGN     = 3'd1;
    localparam logic [2:0] c_MODE_UNSIGNED = 3'd2;
    localparam logic [2:0] c_MODE_SHAMT    = 3'd3;
    localparam logic [2:0] c_MODE_BRANCH   = 3'd4;
`ifdef IMM_LUI_EN
    localparam logic [2:0] c_MODE_UPPER    = 3'd5;
`endif

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
`ifdef IMM_LUI_EN
    logic [DATA_W-1:0] w_upper;
`endif
    logic [DATA_W-1:0] w_data;
    logic [2:0]        w_mode;
    logic              w_unused;

    assign w_op     = in_instr[31:26];
    assign w_funct  = in_instr[5:0];
    assign w_imm    = in_instr[15:0];
    assign w_shamt  = in_instr[10:6];
    assign w_sext   = DATA_W'($signed(w_imm));
    assign w_zext   = DATA_W'(w_imm);
`ifdef IMM_LUI_EN
    assign w_upper  = DATA_W'($signed({w_imm, 16'h0000}));
`endif
    // rs/rt fields carry no immediate information
    assign w_unused = ^in_instr[25:16];

    always_comb begin
        w_data = '0;
        w_mode = c_MODE_NONE;
        if (w_op == 6'h01) begin
            w_data = '0;
            w_mode = c_MODE_ZERO;
        end else if (w_op == 6'h00 &&
                     (w_funct == 6'h00 || w_funct == 6'h02 || w_funct == 6'h03)) begin
            w_data = DATA_W'(w_shamt);
            w_mode = c_MODE_SHAMT;
        end else begin
            case (w_op)
                6'h04, 6'h05, 6'h06, 6'h07: begin
                    w_data = w_sext << 2;
                    w_mode = c_MODE_BRANCH;
                end
                6'h08, 6'h09, 6'h0a, 6'h0b, 6'h20, 6'h21,
                6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b: begin
                    w_data = w_sext;
                    w_mode = c_MODE_SIGN;
                end
                6'h0c, 6'h0d, 6'h0e: begin
                    w_data = w_zext;
                    w_mode = c_MODE_UNSIGNED;
                end
`ifdef IMM_LUI_EN
                6'h0f: begin
                    w_data = w_upper;
                    w_mode = c_MODE_UPPER;
                end
`endif
                default: begin
                    w_data = '0;
                    w_mode = c_MODE_NONE;
                end
            endcase
        end
    end

    // Two-slot circular buffer; pointers wrap naturally at one bit
    logic [DATA_W-1:0] r_data [2];
    logic [2:0]        r_mode [2];
    logic [TAG_W-1:0]  r_tag  [2];
    logic              r_rd;
    logic              r_wr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign out_data  = r_data[r_rd];
    assign out_mode  = r_mode[r_rd];
    assign out_tag   = r_tag[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_mode[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= w_data;
                r_mode[r_wr] <= w_mode;
                r_tag[r_wr]  <= in_tag;
                r_wr         <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
